// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl
// Sequencer for the matrix-multiply datapath. It fetches A rows, B rows and,
// optionally, C-bias elements from the scratchpad into the datapath operand
// registers. It then pulses the datapath start, waits for completion, writes
// the biased result matrix back, and reports done/error/overflow status.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               request pulse, sampled only in IDLE
//   mode_i                1 = load C bias, 0 = zero bias
//   n/k/m_dim_i           matrix dimensions (A is NxK, B is KxM)
//   read_target_i         scratchpad bank for C-bias reads
//   write_target_i        scratchpad bank for result writes
//   sp_addr_o/rd/wr       single scratchpad port owned by this block
//   sp_rdata_i/sp_wdata_o scratchpad read / write data
//   ld_a/b/c_o, ld_idx_o, ld_data_o  operand load strobes, index and data
//   calc_start_o          one-cycle start pulse to the datapath
//   calc_done_i           datapath finished (level or pulse)
//   res_idx_o, res_data_i result element select / biased result element
//   flags_i, ovf_o        per-element overflow flags in, sticky copy out
//   wb_done_o             one-cycle pulse: writeback complete
//   busy_o, done_o, err_o status
//   dbg_state_o           current FSM state, for observation only
//
// Strobe semantics: every strobe (sp_rd_o, sp_wr_o, ld_*_o, calc_start_o,
// wb_done_o, done_o) is a registered single-cycle qualifier with no ready
// back-pressure. A read issued with sp_rd_o in cycle t has its data sampled
// from sp_rdata_i at the end of cycle t and presented on ld_*_o/ld_idx_o/
// ld_data_o in cycle t+1. A write is complete in the cycle sp_wr_o is high.

module matmul_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int NELEM     = MAX_DIM * MAX_DIM,
    localparam int IDX_W     = (NELEM > 1) ? $clog2(NELEM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [2:0]            n_dim_i,
    input  logic [2:0]            k_dim_i,
    input  logic [2:0]            m_dim_i,
    input  logic [2:0]            read_target_i,
    input  logic [2:0]            write_target_i,
    output logic [ADDR_WIDTH-1:0] sp_addr_o,
    output logic                  sp_rd_o,
    input  logic [BUS_WIDTH-1:0]  sp_rdata_i,
    output logic                  sp_wr_o,
    output logic [BUS_WIDTH-1:0]  sp_wdata_o,
    output logic                  ld_a_o,
    output logic                  ld_b_o,
    output logic                  ld_c_o,
    output logic [IDX_W-1:0]      ld_idx_o,
    output logic [BUS_WIDTH-1:0]  ld_data_o,
    output logic                  calc_start_o,
    input  logic                  calc_done_i,
    output logic [IDX_W-1:0]      res_idx_o,
    input  logic [BUS_WIDTH-1:0]  res_data_i,
    input  logic [NELEM-1:0]      flags_i,
    output logic                  wb_done_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [NELEM-1:0]      ovf_o,
    output logic [3:0]            dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE, LD_A, LD_B, LD_C, DRAIN, START, WAIT, WB, DONE
    } state_t;

    localparam logic [4:0]       CODE_A    = 5'b00100;
    localparam logic [4:0]       CODE_B    = 5'b01000;
    localparam logic [4:0]       CODE_C    = 5'b10000;
    localparam logic [IDX_W-1:0] ROW_LAST  = IDX_W'(MAX_DIM - 1);
    localparam logic [IDX_W-1:0] ELEM_LAST = IDX_W'(NELEM - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = '0;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             mode_q;
    logic [2:0]       rd_bank_q;
    logic [2:0]       wr_bank_q;
    logic             dims_bad;

    function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [4:0]       code,
                                                      input logic [IDX_W-1:0] idx,
                                                      input logic [2:0]       bank);
        logic [ADDR_WIDTH-1:0] a;
        a                 = '0;
        a[4:0]            = code;
        a[5 +: IDX_W]     = idx;
        a[5 + IDX_W +: 3] = bank;
        return a;
    endfunction

    function automatic logic dim_bad(input logic [2:0] d);
        return (d == 3'd0) || (int'({29'd0, d}) > MAX_DIM);
    endfunction

    assign dims_bad    = dim_bad(n_dim_i) || dim_bad(k_dim_i) || dim_bad(m_dim_i);
    // The result element is combinational from res_idx_o, so the write data
    // follows it directly; gating by sp_wr_o keeps it 0 outside writeback.
    assign sp_wdata_o  = sp_wr_o ? res_data_i : '0;
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            mode_q       <= 1'b0;
            rd_bank_q    <= '0;
            wr_bank_q    <= '0;
            sp_addr_o    <= '0;
            sp_rd_o      <= 1'b0;
            sp_wr_o      <= 1'b0;
            ld_a_o       <= 1'b0;
            ld_b_o       <= 1'b0;
            ld_c_o       <= 1'b0;
            ld_idx_o     <= '0;
            ld_data_o    <= '0;
            calc_start_o <= 1'b0;
            res_idx_o    <= '0;
            wb_done_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            ovf_o        <= '0;
        end else begin
            sp_rd_o      <= 1'b0;
            sp_wr_o      <= 1'b0;
            ld_a_o       <= 1'b0;
            ld_b_o       <= 1'b0;
            ld_c_o       <= 1'b0;
            calc_start_o <= 1'b0;
            wb_done_o    <= 1'b0;
            done_o       <= 1'b0;

            // Every load-state cycle has a read in flight; capture it for
            // presentation in the following cycle.
            if (state == LD_A || state == LD_B || state == LD_C) begin
                ld_idx_o  <= cnt;
                ld_data_o <= sp_rdata_i;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        rd_bank_q <= read_target_i;
                        wr_bank_q <= write_target_i;
                        ovf_o     <= '0;
                        busy_o    <= 1'b1;
                        cnt       <= '0;
                        if (dims_bad) begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_o     <= 1'b0;
                            sp_rd_o   <= 1'b1;
                            sp_addr_o <= mk_addr(CODE_A, IDX_ZERO, 3'd0);
                            state     <= LD_A;
                        end
                    end
                end
                LD_A: begin
                    ld_a_o  <= 1'b1;
                    sp_rd_o <= 1'b1;
                    if (cnt == ROW_LAST) begin
                        cnt       <= '0;
                        sp_addr_o <= mk_addr(CODE_B, IDX_ZERO, 3'd0);
                        state     <= LD_B;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        sp_addr_o <= mk_addr(CODE_A, cnt + 1'b1, 3'd0);
                    end
                end
                LD_B: begin
                    ld_b_o <= 1'b1;
                    if (cnt != ROW_LAST) begin
                        cnt       <= cnt + 1'b1;
                        sp_rd_o   <= 1'b1;
                        sp_addr_o <= mk_addr(CODE_B, cnt + 1'b1, 3'd0);
                    end else if (mode_q) begin
                        cnt       <= '0;
                        sp_rd_o   <= 1'b1;
                        sp_addr_o <= mk_addr(CODE_C, IDX_ZERO, rd_bank_q);
                        state     <= LD_C;
                    end else begin
                        state <= DRAIN;
                    end
                end
                LD_C: begin
                    ld_c_o <= 1'b1;
                    if (cnt == ELEM_LAST) begin
                        state <= DRAIN;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        sp_rd_o   <= 1'b1;
                        sp_addr_o <= mk_addr(CODE_C, cnt + 1'b1, rd_bank_q);
                    end
                end
                DRAIN: begin
                    calc_start_o <= 1'b1;
                    state        <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (calc_done_i) begin
                        cnt       <= '0;
                        sp_wr_o   <= 1'b1;
                        res_idx_o <= '0;
                        sp_addr_o <= mk_addr(CODE_C, IDX_ZERO, wr_bank_q);
                        state     <= WB;
                    end
                end
                WB: begin
                    // Flags are valid for the finished result; take them once.
                    if (cnt == IDX_ZERO) begin
                        ovf_o <= ovf_o | flags_i;
                    end
                    if (cnt == ELEM_LAST) begin
                        done_o    <= 1'b1;
                        wb_done_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        sp_wr_o   <= 1'b1;
                        res_idx_o <= cnt + 1'b1;
                        sp_addr_o <= mk_addr(CODE_C, cnt + 1'b1, wr_bank_q);
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl
// Directed bench for matmul_seq_ctrl with MAX_DIM = 2. A scratchpad model
// returns A = {1,2;3,4}, B = {5,6;7,8} and C bias = 1 (bank 2 only); a
// datapath stand-in multiplies the captured operands. Expected addresses,
// cycles and results are hand-computed constants.

module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [2:0]  n_dim_i = 3'd0;
    logic [2:0]  k_dim_i = 3'd0;
    logic [2:0]  m_dim_i = 3'd0;
    logic [2:0]  read_target_i = 3'd0;
    logic [2:0]  write_target_i = 3'd0;
    logic [31:0] sp_addr_o;
    logic        sp_rd_o;
    logic [15:0] sp_rdata_i;
    logic        sp_wr_o;
    logic [15:0] sp_wdata_o;
    logic        ld_a_o, ld_b_o, ld_c_o;
    logic [1:0]  ld_idx_o;
    logic [15:0] ld_data_o;
    logic        calc_start_o;
    logic        calc_done_i = 1'b0;
    logic [1:0]  res_idx_o;
    logic [15:0] res_data_i;
    logic [3:0]  flags_i = 4'd0;
    logic        wb_done_o, busy_o, done_o, err_o;
    logic [3:0]  ovf_o;
    logic [3:0]  dbg_state_o;

    matmul_seq_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
        .read_target_i(read_target_i), .write_target_i(write_target_i),
        .sp_addr_o(sp_addr_o), .sp_rd_o(sp_rd_o), .sp_rdata_i(sp_rdata_i),
        .sp_wr_o(sp_wr_o), .sp_wdata_o(sp_wdata_o),
        .ld_a_o(ld_a_o), .ld_b_o(ld_b_o), .ld_c_o(ld_c_o),
        .ld_idx_o(ld_idx_o), .ld_data_o(ld_data_o),
        .calc_start_o(calc_start_o), .calc_done_i(calc_done_i),
        .res_idx_o(res_idx_o), .res_data_i(res_data_i), .flags_i(flags_i),
        .wb_done_o(wb_done_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .ovf_o(ovf_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scratchpad and datapath models ----------------
    always_comb begin
        sp_rdata_i = 16'hBAD0;
        case (sp_addr_o[4:0])
            5'b00100: sp_rdata_i = sp_addr_o[5] ? 16'h0403 : 16'h0201;
            5'b01000: sp_rdata_i = sp_addr_o[5] ? 16'h0807 : 16'h0605;
            5'b10000: if (sp_addr_o[9:7] == 3'd2) sp_rdata_i = 16'h0001;
            default: ;
        endcase
    end

    logic [15:0] res_mem [4];
    logic [15:0] a_cap [2];
    logic [15:0] b_cap [2];
    logic [15:0] c_cap [4];
    assign res_data_i = res_mem[res_idx_o];

    // ---------------- monitor logs ----------------
    logic [31:0] rd_addr_q [$];
    int          rd_cyc_q [$];
    logic [31:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q [$];
    int          ld_kind_q [$];
    logic [1:0]  ld_idx_q [$];
    logic [15:0] ld_data_q [$];
    int          ld_cyc_q [$];
    int          done_cyc_q [$];
    logic        done_err_q [$];
    logic        done_wbd_q [$];
    int          cs_cyc_q [$];
    int          overlap_n = 0;
    int          busy_n = 0;

    always @(negedge clk) begin
        if (sp_rd_o) begin
            rd_addr_q.push_back(sp_addr_o);
            rd_cyc_q.push_back(cyc - base);
        end
        if (sp_wr_o) begin
            wr_addr_q.push_back(sp_addr_o);
            wr_data_q.push_back(sp_wdata_o);
            wr_cyc_q.push_back(cyc - base);
        end
        if (sp_rd_o && sp_wr_o) overlap_n++;
        if (busy_o) busy_n++;
        if (ld_a_o || ld_b_o || ld_c_o) begin
            ld_kind_q.push_back(ld_a_o ? 0 : (ld_b_o ? 1 : 2));
            ld_idx_q.push_back(ld_idx_o);
            ld_data_q.push_back(ld_data_o);
            ld_cyc_q.push_back(cyc - base);
            if (ld_a_o) a_cap[ld_idx_o[0]] = ld_data_o;
            if (ld_b_o) b_cap[ld_idx_o[0]] = ld_data_o;
            if (ld_c_o) c_cap[ld_idx_o] = ld_data_o;
        end
        if (calc_start_o) cs_cyc_q.push_back(cyc - base);
        if (done_o) begin
            done_cyc_q.push_back(cyc - base);
            done_err_q.push_back(err_o);
            done_wbd_q.push_back(wb_done_o);
        end
    end

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q [$];
    int s_rd, s_wr, s_ld, s_done, s_cs, s_ov, s_busy;

    task automatic snap();
        s_rd   = rd_addr_q.size();
        s_wr   = wr_addr_q.size();
        s_ld   = ld_kind_q.size();
        s_done = done_cyc_q.size();
        s_cs   = cs_cyc_q.size();
        s_ov   = overlap_n;
        s_busy = busy_n;
    endtask

    task automatic model_calc(input logic m);
        int s;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'(a_cap[i][k*8 +: 8]) * int'(b_cap[k][j*8 +: 8]);
                if (m) s += int'(c_cap[i*2+j]);
                res_mem[i*2+j] = 16'(s);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic m, input logic [2:0] n, input logic [2:0] k,
                          input logic [2:0] mm, input logic [2:0] rt, input logic [2:0] wt,
                          input int dly, input bit inj,
                          input logic [3:0] fl_first, input logic [3:0] fl_rest);
        int t;
        @(posedge clk); #1;
        mode_i = m; n_dim_i = n; k_dim_i = k; m_dim_i = mm;
        read_target_i = rt; write_target_i = wt;
        start_i = 1'b1;
        base = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (!calc_start_o && !done_o && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (calc_start_o) begin
            model_calc(m);
            @(posedge clk); #1;
            for (int d = 0; d < dly; d++) begin
                start_i = inj && (d == 0);
                @(posedge clk); #1;
            end
            start_i = 1'b0;
            calc_done_i = 1'b1;
            flags_i = fl_first;
            @(posedge clk); #1;
            calc_done_i = 1'b0;
            start_i = inj;
            @(posedge clk); #1;
            start_i = 1'b0;
            flags_i = fl_rest;
        end
        while (!done_o && t < 200) begin
            @(posedge clk); #1; t++;
        end
        n_chk++;
        if (t >= 200) begin
            $display("FAIL run_timeout: done_o not seen within %0d cycles", t); n_fail++;
        end
        repeat (3) begin @(posedge clk); #1; end
        flags_i = 4'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({sp_addr_o, sp_wdata_o, ld_data_o} !== 64'd0) begin
            $display("FAIL reset_data: addr=%h wdata=%h ld_data=%h required 0", sp_addr_o, sp_wdata_o, ld_data_o); n_fail++;
        end
        n_chk++;
        if ({ld_idx_o, res_idx_o} !== 4'd0) begin
            $display("FAIL reset_idx: ld_idx=%0d res_idx=%0d required 0", ld_idx_o, res_idx_o); n_fail++;
        end
        n_chk++;
        if ({sp_rd_o, sp_wr_o, ld_a_o, ld_b_o, ld_c_o, calc_start_o, wb_done_o} !== 7'd0) begin
            $display("FAIL reset_strobes: rd=%b wr=%b lda=%b ldb=%b ldc=%b cs=%b wbd=%b required 0",
                     sp_rd_o, sp_wr_o, ld_a_o, ld_b_o, ld_c_o, calc_start_o, wb_done_o); n_fail++;
        end
        n_chk++;
        if ({busy_o, done_o, err_o, ovf_o} !== 7'd0) begin
            $display("FAIL reset_status: busy=%b done=%b err=%b ovf=%b required 0", busy_o, done_o, err_o, ovf_o); n_fail++;
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++;
        if ({busy_o, sp_rd_o, sp_wr_o, done_o} !== 4'd0) begin
            $display("FAIL reset_idle: busy=%b rd=%b wr=%b done=%b required 0 with no start", busy_o, sp_rd_o, sp_wr_o, done_o); n_fail++;
        end
    endtask

    task automatic test_mode0();
        logic [31:0] exp_rd [4] = '{32'h04, 32'h24, 32'h08, 32'h28};
        logic [15:0] exp_ld [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
        snap();
        run_op(1'b0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 0, 1'b0, 4'd0, 4'd0);
        n_chk++;
        if (rd_addr_q.size() - s_rd != 4) begin
            $display("FAIL m0_rd_count: got %0d required 4", rd_addr_q.size() - s_rd); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_addr_q[s_rd+i] !== exp_rd[i] || rd_cyc_q[s_rd+i] != i + 1) begin
                $display("FAIL m0_rd%0d: addr=%h cyc=%0d required addr=%h cyc=%0d",
                         i, rd_addr_q[s_rd+i], rd_cyc_q[s_rd+i], exp_rd[i], i + 1); n_fail++;
            end
            n_chk++;
            if (ld_kind_q[s_ld+i] != i / 2 || ld_idx_q[s_ld+i] !== 2'(i % 2) ||
                ld_data_q[s_ld+i] !== exp_ld[i] || ld_cyc_q[s_ld+i] != i + 2) begin
                $display("FAIL m0_ld%0d: kind=%0d idx=%0d data=%h cyc=%0d required kind=%0d idx=%0d data=%h cyc=%0d",
                         i, ld_kind_q[s_ld+i], ld_idx_q[s_ld+i], ld_data_q[s_ld+i], ld_cyc_q[s_ld+i],
                         i / 2, i % 2, exp_ld[i], i + 2); n_fail++;
            end
        end
        n_chk++;
        if (cs_cyc_q.size() - s_cs != 1 || cs_cyc_q[s_cs] != 6) begin
            $display("FAIL m0_calc_start: count=%0d cyc=%0d required 1 at 6", cs_cyc_q.size() - s_cs, cs_cyc_q[s_cs]); n_fail++;
        end
        exp_q = '{16'd19, 16'd22, 16'd43, 16'd50};
        n_chk++;
        if (wr_addr_q.size() - s_wr != 4) begin
            $display("FAIL m0_wr_count: got %0d required 4", wr_addr_q.size() - s_wr); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_data_q[s_wr+i] !== e || wr_addr_q[s_wr+i] !== 32'h90 + 32'(i * 32) || wr_cyc_q[s_wr+i] != 8 + i) begin
                $display("FAIL m0_wr%0d: data=%0d addr=%h cyc=%0d required data=%0d addr=%h cyc=%0d",
                         i, wr_data_q[s_wr+i], wr_addr_q[s_wr+i], wr_cyc_q[s_wr+i], e, 32'h90 + 32'(i * 32), 8 + i); n_fail++;
            end
        end
        n_chk++;
        if (done_cyc_q.size() - s_done != 1 || done_cyc_q[s_done] != 12 ||
            done_err_q[s_done] !== 1'b0 || done_wbd_q[s_done] !== 1'b1) begin
            $display("FAIL m0_done: count=%0d cyc=%0d err=%b wbd=%b required 1 at 12 err=0 wbd=1",
                     done_cyc_q.size() - s_done, done_cyc_q[s_done], done_err_q[s_done], done_wbd_q[s_done]); n_fail++;
        end
        n_chk++;
        if (busy_n - s_busy != 12 || overlap_n != s_ov) begin
            $display("FAIL m0_busy: busy cycles=%0d overlap=%0d required 12 and 0", busy_n - s_busy, overlap_n - s_ov); n_fail++;
        end
    endtask

    task automatic test_mode1();
        snap();
        run_op(1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 0, 1'b0, 4'd0, 4'd0);
        n_chk++;
        if (rd_addr_q.size() - s_rd != 8) begin
            $display("FAIL m1_rd_count: got %0d required 8", rd_addr_q.size() - s_rd); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_addr_q[s_rd+4+i] !== 32'h110 + 32'(i * 32) || rd_cyc_q[s_rd+4+i] != 5 + i) begin
                $display("FAIL m1_crd%0d: addr=%h cyc=%0d required addr=%h cyc=%0d",
                         i, rd_addr_q[s_rd+4+i], rd_cyc_q[s_rd+4+i], 32'h110 + 32'(i * 32), 5 + i); n_fail++;
            end
            n_chk++;
            if (ld_kind_q[s_ld+4+i] != 2 || ld_idx_q[s_ld+4+i] !== 2'(i) ||
                ld_data_q[s_ld+4+i] !== 16'd1 || ld_cyc_q[s_ld+4+i] != 6 + i) begin
                $display("FAIL m1_ldc%0d: kind=%0d idx=%0d data=%h cyc=%0d required kind=2 idx=%0d data=1 cyc=%0d",
                         i, ld_kind_q[s_ld+4+i], ld_idx_q[s_ld+4+i], ld_data_q[s_ld+4+i], ld_cyc_q[s_ld+4+i], i, 6 + i); n_fail++;
            end
        end
        n_chk++;
        if (cs_cyc_q[s_cs] != 10) begin
            $display("FAIL m1_calc_start: cyc=%0d required 10", cs_cyc_q[s_cs]); n_fail++;
        end
        exp_q = '{16'd20, 16'd23, 16'd44, 16'd51};
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_data_q[s_wr+i] !== e || wr_addr_q[s_wr+i] !== 32'h90 + 32'(i * 32) || wr_cyc_q[s_wr+i] != 12 + i) begin
                $display("FAIL m1_wr%0d: data=%0d addr=%h cyc=%0d required data=%0d addr=%h cyc=%0d",
                         i, wr_data_q[s_wr+i], wr_addr_q[s_wr+i], wr_cyc_q[s_wr+i], e, 32'h90 + 32'(i * 32), 12 + i); n_fail++;
            end
        end
        n_chk++;
        if (done_cyc_q.size() - s_done != 1 || done_cyc_q[s_done] != 16 || busy_n - s_busy != 16) begin
            $display("FAIL m1_done: count=%0d cyc=%0d busy=%0d required 1 at 16 busy=16",
                     done_cyc_q.size() - s_done, done_cyc_q[s_done], busy_n - s_busy); n_fail++;
        end
    endtask

    task automatic test_error();
        logic [2:0] bad_n [2] = '{3'd0, 3'd2};
        logic [2:0] bad_k [2] = '{3'd2, 3'd3};
        for (int c = 0; c < 2; c++) begin
            snap();
            run_op(1'b0, bad_n[c], bad_k[c], 3'd2, 3'd0, 3'd1, 0, 1'b0, 4'd0, 4'd0);
            n_chk++;
            if (done_cyc_q.size() - s_done != 1 || done_cyc_q[s_done] != 1 ||
                done_err_q[s_done] !== 1'b1 || done_wbd_q[s_done] !== 1'b0) begin
                $display("FAIL err%0d_done: count=%0d cyc=%0d err=%b wbd=%b required 1 at 1 err=1 wbd=0",
                         c, done_cyc_q.size() - s_done, done_cyc_q[s_done], done_err_q[s_done], done_wbd_q[s_done]); n_fail++;
            end
            n_chk++;
            if (rd_addr_q.size() != s_rd || wr_addr_q.size() != s_wr || busy_n - s_busy != 1) begin
                $display("FAIL err%0d_traffic: rd=%0d wr=%0d busy=%0d required 0 0 1",
                         c, rd_addr_q.size() - s_rd, wr_addr_q.size() - s_wr, busy_n - s_busy); n_fail++;
            end
            n_chk++;
            if (err_o !== 1'b1) begin
                $display("FAIL err%0d_hold: err_o=%b required 1 after done", c, err_o); n_fail++;
            end
        end
    endtask

    task automatic test_ignore_start();
        snap();
        run_op(1'b0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 3, 1'b1, 4'd0, 4'd0);
        n_chk++;
        if (done_cyc_q.size() - s_done != 1 || done_cyc_q[s_done] != 15 || done_err_q[s_done] !== 1'b0) begin
            $display("FAIL ign_done: count=%0d cyc=%0d err=%b required 1 at 15 err=0",
                     done_cyc_q.size() - s_done, done_cyc_q[s_done], done_err_q[s_done]); n_fail++;
        end
        n_chk++;
        if (wr_addr_q.size() - s_wr != 4 || rd_addr_q.size() - s_rd != 4 || cs_cyc_q.size() - s_cs != 1) begin
            $display("FAIL ign_counts: wr=%0d rd=%0d cs=%0d required 4 4 1",
                     wr_addr_q.size() - s_wr, rd_addr_q.size() - s_rd, cs_cyc_q.size() - s_cs); n_fail++;
        end
        exp_q = '{16'd19, 16'd22, 16'd43, 16'd50};
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_data_q[s_wr+i] !== e) begin
                $display("FAIL ign_wr%0d: data=%0d required %0d", i, wr_data_q[s_wr+i], e); n_fail++;
            end
        end
    endtask

    task automatic test_ovf();
        snap();
        run_op(1'b0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 0, 1'b0, 4'b0100, 4'b0011);
        n_chk++;
        if (ovf_o !== 4'b0100) begin
            $display("FAIL ovf_latch: ovf_o=%b required 0100", ovf_o); n_fail++;
        end
        run_op(1'b0, 3'd2, 3'd3, 3'd2, 3'd0, 3'd1, 0, 1'b0, 4'd0, 4'd0);
        n_chk++;
        if (ovf_o !== 4'b0000 || err_o !== 1'b1) begin
            $display("FAIL ovf_clear: ovf_o=%b err_o=%b required 0000 and 1", ovf_o, err_o); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        snap();
        @(posedge clk); #1;
        mode_i = 1'b0; n_dim_i = 3'd2; k_dim_i = 3'd2; m_dim_i = 3'd2; write_target_i = 3'd1;
        start_i = 1'b1;
        base = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (!calc_start_o && t < 100) begin @(posedge clk); #1; t++; end
        n_chk++;
        if (t >= 100) begin
            $display("FAIL rstmid_timeout: calc_start_o not seen"); n_fail++;
        end
        model_calc(1'b0);
        @(posedge clk); #1;
        calc_done_i = 1'b1;
        @(posedge clk); #1;
        calc_done_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({sp_addr_o, sp_wdata_o, ld_data_o, ld_idx_o, res_idx_o} !== 68'd0 ||
            {sp_rd_o, sp_wr_o, ld_a_o, ld_b_o, ld_c_o, calc_start_o, wb_done_o,
             busy_o, done_o, err_o, ovf_o} !== 14'd0) begin
            $display("FAIL rstmid_outputs: addr=%h wdata=%h wr=%b busy=%b res_idx=%0d required all 0",
                     sp_addr_o, sp_wdata_o, sp_wr_o, busy_o, res_idx_o); n_fail++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++;
        if (wr_addr_q.size() - s_wr != 2 || done_cyc_q.size() != s_done || busy_o !== 1'b0) begin
            $display("FAIL rstmid_abort: wr=%0d done=%0d busy=%b required 2 0 0",
                     wr_addr_q.size() - s_wr, done_cyc_q.size() - s_done, busy_o); n_fail++;
        end
        snap();
        run_op(1'b0, 3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 0, 1'b0, 4'd0, 4'd0);
        exp_q = '{16'd19, 16'd22, 16'd43, 16'd50};
        n_chk++;
        if (wr_addr_q.size() - s_wr != 4 || done_cyc_q.size() - s_done != 1 || done_cyc_q[s_done] != 12) begin
            $display("FAIL rstmid_rerun: wr=%0d done=%0d cyc=%0d required 4 1 12",
                     wr_addr_q.size() - s_wr, done_cyc_q.size() - s_done, done_cyc_q[s_done]); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_data_q[s_wr+i] !== e) begin
                $display("FAIL rstmid_wr%0d: data=%0d required %0d", i, wr_data_q[s_wr+i], e); n_fail++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            res_mem[i] = 16'd0;
            c_cap[i]   = 16'd0;
        end
        for (int i = 0; i < 2; i++) begin
            a_cap[i] = 16'd0;
            b_cap[i] = 16'd0;
        end
        test_reset();
        test_mode0();
        test_mode1();
        test_error();
        test_ignore_start();
        test_ovf();
        test_reset_mid();
        n_chk++;
        if (overlap_n != 0) begin
            $display("FAIL rd_wr_overlap: %0d cycles with both strobes, required 0", overlap_n); n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
